// File: rtl/des3_pkg.sv
// Shared types, DES permutation tables and key-preparation helpers for the
// 3DES key schedule.
package des3_pkg;

    typedef logic [55:0] key56_t;
    typedef logic [27:0] half28_t;
    typedef logic [47:0] subkey48_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_K1   = 2'd1,
        ST_K2   = 2'd2,
        ST_K3   = 2'd3
    } stage_t;

    typedef enum logic [2:0] {
        CD_HOLD,
        CD_LOAD,
        CD_ROTL1,
        CD_ROTL2,
        CD_ROTR1,
        CD_ROTR2
    } cd_op_t;

    // Tables use DES numbering: entry value n selects input bit n, bit 1 = MSB.
    localparam int PC1_TABLE [0:55] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TABLE [0:47] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam int SHIFT_SCHEDULE [0:15] = '{
        1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
    };

    // Seven key bits per byte, MSB first, odd parity in the byte LSB.
    function automatic logic [63:0] parity_expand(input key56_t chunk);
        logic [63:0] expanded;
        logic [6:0]  byteBits;
        expanded = '0;
        for (int j = 0; j < 8; j++) begin
            byteBits = chunk[55 - 7*j -: 7];
            expanded[63 - 8*j -: 8] = {byteBits, ~^byteBits};
        end
        return expanded;
    endfunction

    function automatic key56_t pc1(input logic [63:0] key);
        key56_t cd;
        for (int i = 0; i < 56; i++) begin
            cd[55 - i] = key[64 - PC1_TABLE[i]];
        end
        return cd;
    endfunction

    function automatic subkey48_t pc2(input half28_t c, input half28_t d);
        key56_t    cd;
        subkey48_t sk;
        cd = {c, d};
        for (int i = 0; i < 48; i++) begin
            sk[47 - i] = cd[56 - PC2_TABLE[i]];
        end
        return sk;
    endfunction

endpackage

// File: rtl/des3_key_schedule_if.sv
// Subkey stream between the key schedule (master) and the DES core (slave).
interface des3_key_schedule_if;

    des3_pkg::subkey48_t subkey;
    logic                sk_valid;
    logic                sk_ready;
    logic [1:0]          stage;
    logic [3:0]          round;
    logic                decrypt;
    logic                block_done;

    modport master (
        output subkey, sk_valid, stage, round, decrypt, block_done,
        input  sk_ready
    );

    modport slave (
        input  subkey, sk_valid, stage, round, decrypt, block_done,
        output sk_ready
    );

endinterface

// File: rtl/des_cd_rotator.sv
// Registered C/D key halves with load and rotate controls; PC-2 of the
// current halves is presented combinationally.
module des_cd_rotator
    import des3_pkg::*;
(
    input  logic      clk,
    input  logic      n_rst,
    input  cd_op_t    cdOp,
    input  half28_t   loadC,
    input  half28_t   loadD,
    output subkey48_t subkey
);

    half28_t cReg;
    half28_t dReg;

    // NOTE: non-blocking assignments so both halves rotate from pre-edge values.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            cReg <= '0;
            dReg <= '0;
        end else begin
            case (cdOp)
                CD_LOAD:  begin cReg <= loadC;                     dReg <= loadD;                     end
                CD_ROTL1: begin cReg <= {cReg[26:0], cReg[27]};    dReg <= {dReg[26:0], dReg[27]};    end
                CD_ROTL2: begin cReg <= {cReg[25:0], cReg[27:26]}; dReg <= {dReg[25:0], dReg[27:26]}; end
                CD_ROTR1: begin cReg <= {cReg[0], cReg[27:1]};     dReg <= {dReg[0], dReg[27:1]};     end
                CD_ROTR2: begin cReg <= {cReg[1:0], cReg[27:2]};   dReg <= {dReg[1:0], dReg[27:2]};   end
                default:  ;
            endcase
        end
    end

    assign subkey = pc2(cReg, dReg);

endmodule

// File: rtl/des3_key_schedule.sv
// 3DES key schedule: latches the ECC session X coordinate as K1/K2/K3 and
// streams 48 EDE-ordered round subkeys per block over a valid/ready handshake.
module des3_key_schedule
    import des3_pkg::*;
#(
    parameter int NUM_BITS   = 163,
    parameter int NUM_ROUNDS = 16
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic [NUM_BITS:0]    ses_x,
    input  logic                 key_load,
    output logic                 key_ready,
    des3_key_schedule_if.master  skBus
);

    localparam int KEY_PAD = 167 - NUM_BITS;

    logic [167:0] key168;
    key56_t       chunk1Q, chunk2Q, chunk3Q;
    stage_t       stageQ, stageD;
    logic [3:0]   roundQ, roundD;
    cd_op_t       cdOp;
    key56_t       loadChunk;
    logic         loadRotate;
    key56_t       loadCd;
    half28_t      loadC, loadD;
    subkey48_t    subkeyW;
    logic         fire;
    logic         lastRound;

    assign key168    = {ses_x, {KEY_PAD{1'b0}}};
    assign fire      = (stageQ != ST_IDLE) && skBus.sk_ready;
    assign lastRound = (roundQ == 4'(NUM_ROUNDS - 1));

    // NOTE: key chunks are cleared on reset so no stale key outlives it.
    always_ff @(posedge clk) begin
        if (n_rst) begin
            stageQ  <= ST_IDLE;
            roundQ  <= '0;
            chunk1Q <= '0;
            chunk2Q <= '0;
            chunk3Q <= '0;
        end else begin
            stageQ <= stageD;
            roundQ <= roundD;
            if (key_load) begin
                chunk1Q <= key168[167:112];
                chunk2Q <= key168[111:56];
                chunk3Q <= key168[55:0];
            end
        end
    end

    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        stageD     = stageQ;
        roundD     = roundQ;
        cdOp       = CD_HOLD;
        loadChunk  = chunk1Q;
        loadRotate = 1'b1;
        if (key_load) begin
            stageD    = ST_K1;
            roundD    = '0;
            cdOp      = CD_LOAD;
            loadChunk = key168[167:112];
        end else if (fire) begin
            if (lastRound) begin
                roundD = '0;
                cdOp   = CD_LOAD;
                case (stageQ)
                    ST_K1: begin stageD = ST_K2; loadChunk = chunk2Q; loadRotate = 1'b0; end
                    ST_K2: begin stageD = ST_K3; loadChunk = chunk3Q; end
                    default: begin stageD = ST_K1; loadChunk = chunk1Q; end
                endcase
            end else begin
                roundD = roundQ + 4'd1;
                // The 1-shift rounds are symmetric, so one lookup serves both directions.
                if (stageQ == ST_K2) begin
                    cdOp = (SHIFT_SCHEDULE[roundD] == 1) ? CD_ROTR1 : CD_ROTR2;
                end else begin
                    cdOp = (SHIFT_SCHEDULE[roundD] == 1) ? CD_ROTL1 : CD_ROTL2;
                end
            end
        end
    end

    // Encrypt stages start at C1/D1; the decrypt stage starts at C0/D0 == C16/D16.
    assign loadCd = pc1(parity_expand(loadChunk));
    assign loadC  = loadRotate ? {loadCd[54:28], loadCd[55]} : loadCd[55:28];
    assign loadD  = loadRotate ? {loadCd[26:0], loadCd[27]}  : loadCd[27:0];

    des_cd_rotator uCdRotator (
        .clk    (clk),
        .n_rst  (n_rst),
        .cdOp   (cdOp),
        .loadC  (loadC),
        .loadD  (loadD),
        .subkey (subkeyW)
    );

    always_comb begin
        skBus.sk_valid   = (stageQ != ST_IDLE);
        skBus.stage      = stageQ;
        skBus.round      = roundQ;
        skBus.decrypt    = (stageQ == ST_K2);
        skBus.subkey     = subkeyW;
        skBus.block_done = fire && lastRound && (stageQ == ST_K3) && !key_load && !n_rst;
        key_ready        = (stageQ != ST_IDLE);
    end

endmodule

// File: tb/tb_des3_key_schedule.sv
// Directed-vector bench for des3_key_schedule using the 133457799BBCDFF1
// known-answer key schedule.
module tb_des3_key_schedule;

    logic         tb_clk = 1'b0;
    logic         n_rst;
    logic [163:0] ses_x;
    logic         key_load;
    logic         key_ready;
    int           checkCount = 0;
    int           errorCount = 0;

    des3_key_schedule_if skBus();

    des3_key_schedule #(
        .NUM_BITS   (163),
        .NUM_ROUNDS (16)
    ) dut (
        .clk       (tb_clk),
        .n_rst     (n_rst),
        .ses_x     (ses_x),
        .key_load  (key_load),
        .key_ready (key_ready),
        .skBus     (skBus)
    );

    always #5 tb_clk = ~tb_clk;

    // {F, F, F[55:4]} with F = 12695BC9B7B7F8.
    localparam logic [163:0] KEY_F = 164'h12695BC9B7B7F8_12695BC9B7B7F8_12695BC9B7B7F;

    localparam logic [47:0] K1_SUBKEYS [0:15] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    // K3 = K1 with key bit 60 cleared (padding nibble), so C0 bit 25 drops out.
    localparam logic [47:0] K3_SUBKEYS [0:15] = '{
        48'h0B02EFFC7072, 48'h79A6D9DBC9E5, 48'h55DC8A42CF99, 48'h72A9D6DB351D,
        48'h3CEC07EB53A8, 48'h63253E507B2F, 48'hEC84B5F618BC, 48'hD78A3AC13BFB,
        48'hE0CBEBEDE781, 48'hB1F307BA464F, 48'h211FD3DED386, 48'h7570F59467E9,
        48'h97C5D0FABA41, 48'h5E43B7F2E73A, 48'hBF910D3D3F0A, 48'hCB3D8B0E17F5
    };

    function automatic logic [47:0] expSubkey(input int idx);
        if (idx < 16)      return K1_SUBKEYS[idx];
        else if (idx < 32) return K1_SUBKEYS[31 - idx];
        else               return K3_SUBKEYS[idx - 32];
    endfunction

    // {stage, round, decrypt, sk_valid} for handshake index 0..47 of a block.
    function automatic logic [7:0] expCtrl(input int idx);
        logic [1:0] st;
        st = 2'(idx / 16 + 1);
        return {st, 4'(idx % 16), st == 2'd2, 1'b1};
    endfunction

    task automatic stepClk();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic loadKey(input logic [163:0] key);
        ses_x    = key;
        key_load = 1'b1;
        stepClk();
        key_load = 1'b0;
    endtask

    task automatic test_reset();
        n_rst    = 1'b1;
        key_load = 1'b1;
        ses_x    = KEY_F;
        skBus.sk_ready = 1'b1;
        stepClk();
        stepClk();
        n_rst    = 1'b0;
        key_load = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge tb_clk);
            checkCount++;
            if ({skBus.subkey, skBus.sk_valid, skBus.stage, skBus.round, skBus.decrypt,
                 skBus.block_done, key_ready} !== 58'd0) begin
                errorCount++;
                $display("FAIL reset_outputs cycle %0d got subkey=%h valid=%b stage=%0d round=%0d ready=%b expected all 0",
                         c, skBus.subkey, skBus.sk_valid, skBus.stage, skBus.round, key_ready);
            end
            stepClk();
        end
    endtask

    task automatic test_known_answer();
        skBus.sk_ready = 1'b1;
        loadKey(KEY_F);
        for (int i = 0; i < 48; i++) begin
            @(negedge tb_clk);
            checkCount++;
            if (skBus.subkey !== expSubkey(i)) begin
                errorCount++;
                $display("FAIL ka_subkey[%0d] got %h expected %h", i, skBus.subkey, expSubkey(i));
            end
            checkCount++;
            if ({skBus.stage, skBus.round, skBus.decrypt, skBus.sk_valid} !== expCtrl(i)) begin
                errorCount++;
                $display("FAIL ka_ctrl[%0d] got %h expected %h", i,
                         {skBus.stage, skBus.round, skBus.decrypt, skBus.sk_valid}, expCtrl(i));
            end
            checkCount++;
            if (skBus.block_done !== (i == 47)) begin
                errorCount++;
                $display("FAIL ka_block_done[%0d] got %b expected %b", i, skBus.block_done, i == 47);
            end
            if (i == 0) begin
                checkCount++;
                if (key_ready !== 1'b1) begin
                    errorCount++;
                    $display("FAIL ka_key_ready got %b expected 1", key_ready);
                end
            end
            stepClk();
        end
    endtask

    task automatic test_backpressure();
        skBus.sk_ready = 1'b1;
        loadKey(KEY_F);
        stepClk();
        stepClk();
        stepClk();
        skBus.sk_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge tb_clk);
            checkCount++;
            if ({skBus.subkey, skBus.stage, skBus.round, skBus.decrypt, skBus.sk_valid, skBus.block_done}
                !== {K1_SUBKEYS[3], expCtrl(3), 1'b0}) begin
                errorCount++;
                $display("FAIL stall_hold cycle %0d got subkey=%h ctrl=%h done=%b expected subkey=%h ctrl=%h done=0",
                         c, skBus.subkey, {skBus.stage, skBus.round, skBus.decrypt, skBus.sk_valid},
                         skBus.block_done, K1_SUBKEYS[3], expCtrl(3));
            end
            stepClk();
        end
        skBus.sk_ready = 1'b1;
        for (int i = 3; i < 6; i++) begin
            @(negedge tb_clk);
            checkCount++;
            if ({skBus.subkey, skBus.stage, skBus.round, skBus.decrypt, skBus.sk_valid}
                !== {K1_SUBKEYS[i], expCtrl(i)}) begin
                errorCount++;
                $display("FAIL stall_resume[%0d] got subkey=%h ctrl=%h expected subkey=%h ctrl=%h", i,
                         skBus.subkey, {skBus.stage, skBus.round, skBus.decrypt, skBus.sk_valid},
                         K1_SUBKEYS[i], expCtrl(i));
            end
            stepClk();
        end
    endtask

    task automatic test_back_to_back();
        int doneCount;
        doneCount = 0;
        skBus.sk_ready = 1'b1;
        loadKey(KEY_F);
        for (int n = 1; n <= 96; n++) begin
            @(negedge tb_clk);
            if (skBus.block_done === 1'b1) doneCount++;
            checkCount++;
            if (skBus.block_done !== (n == 48 || n == 96)) begin
                errorCount++;
                $display("FAIL wrap_block_done handshake %0d got %b expected %b",
                         n, skBus.block_done, (n == 48 || n == 96));
            end
            if (n == 49) begin
                checkCount++;
                if ({skBus.subkey, skBus.stage, skBus.round, skBus.decrypt, skBus.sk_valid}
                    !== {48'h1B02EFFC7072, expCtrl(0)}) begin
                    errorCount++;
                    $display("FAIL wrap_first_subkey got subkey=%h ctrl=%h expected subkey=1b02effc7072 ctrl=%h",
                             skBus.subkey, {skBus.stage, skBus.round, skBus.decrypt, skBus.sk_valid}, expCtrl(0));
                end
            end
            stepClk();
        end
        checkCount++;
        if (doneCount !== 2) begin
            errorCount++;
            $display("FAIL wrap_done_count got %0d expected 2", doneCount);
        end
    endtask

    task automatic test_mid_reload();
        skBus.sk_ready = 1'b1;
        loadKey(KEY_F);
        for (int i = 0; i < 23; i++) stepClk();
        ses_x    = '0;
        key_load = 1'b1;
        @(negedge tb_clk);
        checkCount++;
        if ({skBus.stage, skBus.round, skBus.decrypt, skBus.sk_valid, skBus.block_done} !== {expCtrl(23), 1'b0}) begin
            errorCount++;
            $display("FAIL reload_at_k2r7 got ctrl=%h done=%b expected ctrl=%h done=0",
                     {skBus.stage, skBus.round, skBus.decrypt, skBus.sk_valid}, skBus.block_done, expCtrl(23));
        end
        stepClk();
        key_load = 1'b0;
        @(negedge tb_clk);
        checkCount++;
        if ({skBus.subkey, skBus.stage, skBus.round, skBus.decrypt, skBus.sk_valid} !== {48'h0, expCtrl(0)}) begin
            errorCount++;
            $display("FAIL reload_zero_key got subkey=%h ctrl=%h expected subkey=0 ctrl=%h",
                     skBus.subkey, {skBus.stage, skBus.round, skBus.decrypt, skBus.sk_valid}, expCtrl(0));
        end
        for (int i = 0; i < 47; i++) stepClk();
        // Reload coincident with the 48th handshake must suppress block_done.
        ses_x    = KEY_F;
        key_load = 1'b1;
        @(negedge tb_clk);
        checkCount++;
        if ({skBus.subkey, skBus.stage, skBus.round, skBus.sk_valid, skBus.block_done}
            !== {48'h0, 2'd3, 4'd15, 1'b1, 1'b0}) begin
            errorCount++;
            $display("FAIL reload_at_last got subkey=%h stage=%0d round=%0d done=%b expected subkey=0 stage=3 round=15 done=0",
                     skBus.subkey, skBus.stage, skBus.round, skBus.block_done);
        end
        stepClk();
        key_load = 1'b0;
        @(negedge tb_clk);
        checkCount++;
        if ({skBus.subkey, skBus.stage, skBus.round, skBus.decrypt, skBus.sk_valid} !== {K1_SUBKEYS[0], expCtrl(0)}) begin
            errorCount++;
            $display("FAIL reload_new_key got subkey=%h ctrl=%h expected subkey=%h ctrl=%h",
                     skBus.subkey, {skBus.stage, skBus.round, skBus.decrypt, skBus.sk_valid},
                     K1_SUBKEYS[0], expCtrl(0));
        end
        stepClk();
    endtask

    task automatic test_reset_mid_run();
        skBus.sk_ready = 1'b1;
        loadKey(KEY_F);
        for (int i = 0; i < 5; i++) stepClk();
        n_rst    = 1'b1;
        key_load = 1'b1;
        stepClk();
        n_rst    = 1'b0;
        key_load = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge tb_clk);
            checkCount++;
            if ({skBus.subkey, skBus.sk_valid, skBus.stage, skBus.round, skBus.decrypt,
                 skBus.block_done, key_ready} !== 58'd0) begin
                errorCount++;
                $display("FAIL midrun_reset cycle %0d got subkey=%h valid=%b stage=%0d round=%0d ready=%b expected all 0",
                         c, skBus.subkey, skBus.sk_valid, skBus.stage, skBus.round, key_ready);
            end
            stepClk();
        end
        loadKey(KEY_F);
        @(negedge tb_clk);
        checkCount++;
        if ({skBus.subkey, skBus.stage, skBus.round, skBus.decrypt, skBus.sk_valid, key_ready}
            !== {K1_SUBKEYS[0], expCtrl(0), 1'b1}) begin
            errorCount++;
            $display("FAIL post_reset_load got subkey=%h ctrl=%h ready=%b expected subkey=%h ctrl=%h ready=1",
                     skBus.subkey, {skBus.stage, skBus.round, skBus.decrypt, skBus.sk_valid}, key_ready,
                     K1_SUBKEYS[0], expCtrl(0));
        end
        stepClk();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        n_rst          = 1'b1;
        key_load       = 1'b0;
        ses_x          = '0;
        skBus.sk_ready = 1'b0;
        test_reset();
        test_known_answer();
        test_backpressure();
        test_back_to_back();
        test_mid_reload();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
